burst_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one downstream burst port between N requesters.

---
 rtl/sched_pkg.sv | 14 +
 rtl/rr_pick.sv | 34 +++
 rtl/burst_rr_sched.sv | 116 +++++++++++
 tb/tb_burst_rr_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and helpers for the burst round-robin scheduler.
package sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Index width that stays at least one bit wide when n == 1.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping N-1 to 0.
module rr_pick
   import sched_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]          req_i,
   input  logic [idx_w(N)-1:0]   ptr_i,
   output logic [idx_w(N)-1:0]   win_o,
   output logic                  any_o
);

   localparam int IW = idx_w(N);

   function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= N) s = s - N;
      return IW'(s);
   endfunction

   // Scan from the farthest offset down so the nearest request overwrites last.
   always_comb begin
      win_o = '0;
      any_o = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_i[wrap_idx(ptr_i, k)]) begin
            win_o = wrap_idx(ptr_i, k);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/burst_rr_sched.sv
// Shares one valid/ready burst port among N requesters; grant held until last or MAX_BEATS.
// Grant lands 1 cycle after request; one idle bubble always separates grants.
module burst_rr_sched
   import sched_pkg::*;
#(
   parameter int N         = 4,
   parameter int MAX_BEATS = 16,
   parameter int W         = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req_valid_i,
   input  logic [N-1:0]          req_last_i,
   input  logic [N*W-1:0]        req_data_i,
   output logic [N-1:0]          req_ready_o,
   output logic                  out_valid_o,
   output logic                  out_last_o,
   output logic [W-1:0]          out_data_o,
   input  logic                  out_ready_i,
   output logic [N-1:0]          gnt_o,
   output logic [idx_w(N)-1:0]   out_src_o,
   output logic                  burst_cut_o
);

   localparam int IW = idx_w(N);
   localparam int CW = $clog2(MAX_BEATS + 1);

   state_t          state_q, state_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [IW-1:0]   src_q, src_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            cut_q, cut_d;

   logic [IW-1:0]   win;
   logic            any;
   logic            beat;

   rr_pick #(.N(N)) u_pick (
      .req_i (req_valid_i),
      .ptr_i (ptr_q),
      .win_o (win),
      .any_o (any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         src_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         cut_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         src_q   <= src_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         cut_q   <= cut_d;
      end
   end

   assign beat = out_valid_o & out_ready_i;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      src_d   = src_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      cut_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (any) begin
               state_d = BUSY;
               gnt_d   = N'(1) << win;
               src_d   = win;
               ptr_d   = (win == IW'(N - 1)) ? '0 : win + IW'(1);
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (beat) begin
               cnt_d = cnt_q + CW'(1);
               // Forced release on the MAX_BEATS-th beat is flagged as a cut.
               if (out_last_o || cnt_q == CW'(MAX_BEATS - 1)) begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  src_d   = '0;
                  cut_d   = ~out_last_o;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_valid_o = 1'b0;
      out_last_o  = 1'b0;
      out_data_o  = '0;
      req_ready_o = '0;
      if (state_q == BUSY) begin
         out_valid_o        = req_valid_i[src_q];
         out_last_o         = req_last_i[src_q];
         out_data_o         = req_data_i[src_q * W +: W];
         req_ready_o[src_q] = out_ready_i;
      end
   end

   assign gnt_o       = gnt_q;
   assign out_src_o   = src_q;
   assign burst_cut_o = cut_q;

endmodule

// File: tb/tb_burst_rr_sched.sv
// Directed scenarios plus randomized traffic checked cycle by cycle against a transaction-level model.
module tb_burst_rr_sched;

   localparam int N    = 4;
   localparam int W    = 32;
   localparam int MAXB = 4;

   logic             clk;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_last;
   logic [N*W-1:0]   req_data;
   logic [N-1:0]     req_ready;
   logic             out_valid;
   logic             out_last;
   logic [W-1:0]     out_data;
   logic             out_ready;
   logic [N-1:0]     gnt;
   logic [1:0]       out_src;
   logic             burst_cut;

   int checks = 0;
   int errors = 0;

   // Pending beats per requester: {last, data}
   logic [W:0] q [N][$];

   int m_owner;
   int m_ptr;
   int m_beats;
   bit m_cut;

   int glog[$];
   bit prev_g;
   int ncut;

   burst_rr_sched #(.N(N), .MAX_BEATS(MAXB), .W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_last_i  (req_last),
      .req_data_i  (req_data),
      .req_ready_o (req_ready),
      .out_valid_o (out_valid),
      .out_last_o  (out_last),
      .out_data_o  (out_data),
      .out_ready_i (out_ready),
      .gnt_o       (gnt),
      .out_src_o   (out_src),
      .burst_cut_o (burst_cut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int gl(input int i);
      return (i < glog.size()) ? glog[i] : -1;
   endfunction

   function automatic bit all_empty();
      bit e;
      e = 1'b1;
      for (int i = 0; i < N; i++) if (q[i].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic push(input int r, input int len, input bit with_last);
      for (int b = 0; b < len; b++)
         q[r].push_back({(with_last && b == len - 1), W'($urandom)});
   endtask

   // One cycle: drive at negedge, check just after, then advance the model to the next edge.
   task automatic step(input logic [N-1:0] vmask, input logic ordy);
      logic [N-1:0] v, lst, e_gnt, e_rdy;
      logic [W-1:0] d [N];
      logic [W-1:0] e_dat;
      logic [1:0]   e_src;
      logic         e_vld, e_lst, last_beat;
      bit           found;
      int           c;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (q[i].size() != 0) begin
            v[i]   = vmask[i];
            lst[i] = q[i][0][W] & vmask[i];
            d[i]   = q[i][0][W-1:0];
         end else begin
            v[i]   = 1'b0;
            lst[i] = 1'b0;
            d[i]   = '0;
         end
         req_data[i*W +: W] = d[i];
      end
      req_valid = v;
      req_last  = lst;
      out_ready = ordy;
      #1;
      e_gnt = '0; e_rdy = '0; e_dat = '0; e_src = '0; e_vld = 1'b0; e_lst = 1'b0;
      if (m_owner >= 0) begin
         e_gnt[m_owner] = 1'b1;
         e_rdy[m_owner] = ordy;
         e_src = 2'(m_owner);
         e_vld = v[m_owner];
         e_lst = lst[m_owner];
         e_dat = d[m_owner];
      end
      chk("gnt",       64'(gnt),       64'(e_gnt));
      chk("out_src",   64'(out_src),   64'(e_src));
      chk("burst_cut", 64'(burst_cut), 64'(m_cut));
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("out_valid", 64'(out_valid), 64'(e_vld));
      chk("out_last",  64'(out_last),  64'(e_lst));
      chk("out_data",  64'(out_data),  64'(e_dat));
      if (gnt != '0 && !prev_g) glog.push_back(int'(out_src));
      prev_g = (gnt != '0);
      if (burst_cut) ncut++;

      m_cut = 1'b0;
      if (m_owner < 0) begin
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (!found && v[c]) begin
               found   = 1'b1;
               m_owner = c;
            end
         end
         if (found) begin
            m_ptr   = (m_owner + 1) % N;
            m_beats = 0;
         end
      end else if (v[m_owner] && ordy) begin
         last_beat = q[m_owner][0][W];
         void'(q[m_owner].pop_front());
         m_beats++;
         if (last_beat || m_beats == MAXB) begin
            m_cut   = !last_beat;
            m_owner = -1;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_gnt",       64'(gnt),       64'd0);
      chk("rst_out_src",   64'(out_src),   64'd0);
      chk("rst_burst_cut", 64'(burst_cut), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_out_data",  64'(out_data),  64'd0);
      m_owner = -1; m_ptr = 0; m_beats = 0; m_cut = 1'b0; prev_g = 1'b0;
      for (int i = 0; i < N; i++) q[i].delete();
      req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      glog.delete();
      ncut = 0;
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (c < 300 && !(all_empty() && m_owner < 0)) begin
         step('1, 1'b1);
         c++;
      end
      repeat (2) step('1, 1'b1);
   endtask

   initial begin
      int exp2 [6];
      int exp3 [3];
      int wd;
      logic [N-1:0] vm;
      exp2 = '{0, 1, 2, 3, 0, 1};
      exp3 = '{1, 3, 1};
      rst = 1'b1;
      req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);

      // Single requester, 3-beat burst
      do_reset();
      push(2, 3, 1'b1);
      repeat (6) step('1, 1'b1);
      chk("t1_grants", 64'(glog.size()), 64'd1);
      chk("t1_src",    64'(gl(0)),       64'd2);

      // Everyone valid with 1-beat bursts: strict rotation
      do_reset();
      push(0, 1, 1'b1); push(0, 1, 1'b1);
      push(1, 1, 1'b1); push(1, 1, 1'b1);
      push(2, 1, 1'b1); push(3, 1, 1'b1);
      drain();
      for (int i = 0; i < 6; i++) chk("t2_order", 64'(gl(i)), 64'(exp2[i]));

      // Long burst cut at MAX_BEATS, remainder competes again
      do_reset();
      push(1, 6, 1'b1);
      push(3, 2, 1'b1);
      drain();
      for (int i = 0; i < 3; i++) chk("t3_order", 64'(gl(i)), 64'(exp3[i]));
      chk("t3_cuts", 64'(ncut), 64'd1);

      // Downstream stall mid-burst
      do_reset();
      push(0, 4, 1'b1);
      push(2, 2, 1'b1);
      wd = 0;
      while (wd < 20 && !(m_owner == 0 && m_beats == 2)) begin step('1, 1'b1); wd++; end
      chk("t4_reached", 64'(wd < 20), 64'd1);
      repeat (5) begin
         step('1, 1'b0);
         chk("t4_gnt_hold", 64'(gnt), 64'h1);
         chk("t4_src_hold", 64'(out_src), 64'd0);
      end
      drain();
      chk("t4_order1", 64'(gl(1)), 64'd2);

      // Reset in the middle of beat 2 from requester 3
      do_reset();
      push(3, 4, 1'b1);
      wd = 0;
      while (wd < 20 && !(m_owner == 3 && m_beats == 1)) begin step('1, 1'b1); wd++; end
      step('1, 1'b1);
      chk("t5_busy_before_rst", 64'(gnt), 64'h8);
      do_reset();
      for (int i = 0; i < N; i++) push(i, 1, 1'b1);
      drain();
      chk("t5_first_after_rst", 64'(gl(0)), 64'd0);

      // Granted requester drops valid mid-burst while requester 0 waits
      do_reset();
      push(2, 4, 1'b1);
      push(0, 1, 1'b1);
      step(4'b0100, 1'b1);
      step('1, 1'b1);
      repeat (3) begin
         step(4'b1011, 1'b1);
         chk("t6_hold_gnt", 64'(gnt), 64'h4);
         chk("t6_no_valid", 64'(out_valid), 64'd0);
      end
      drain();
      chk("t6_order0", 64'(gl(0)), 64'd2);
      chk("t6_order1", 64'(gl(1)), 64'd0);

      // Randomized traffic
      do_reset();
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N; i++) begin
            wd = $urandom_range(3, 0);
            for (int b = 0; b < wd; b++) push(i, $urandom_range(7, 1), 1'b1);
         end
         repeat (120) begin
            for (int i = 0; i < N; i++) vm[i] = ($urandom_range(9, 0) != 0);
            step(vm, $urandom_range(3, 0) != 0);
         end
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
